ebox_mem_seq: RTL and testbench

- Sequences one EBOX memory cycle at a time against the MBOX/cache port.
- Latches the microcode request and presents it to the cache with a req/accept handshake.
- Handles cache retry with a re-issue gap, page-fail hold with the forced trap to 1777, and read-pause-write interlock.
- A timeout flags nonexistent memory. Sits between EBOX microcode control and the cache/pager, alongside the MCL decode.

---
 rtl/ebox_mem_pkg.sv | 32 +++
 rtl/mem_timeout_ctr.sv | 36 +++
 rtl/ebox_mem_seq.sv | 197 +++++++++++++++++++
 tb/tb_ebox_mem_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ebox_mem_pkg.sv
// ebox_mem_pkg: shared types and defaults for the EBOX memory-cycle sequencer.
//   mem_op_e     - microcode memory operation encoding
//   mem_state_e  - sequencer state encoding
//   *_DEF        - default retry gap, timeout and retry limit
//   cnt_width()  - counter width able to hold 0..max_val (never below 1 bit)
package ebox_mem_pkg;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_WRITE = 2'd1,
        MEM_RPW   = 2'd2,
        MEM_WAR   = 2'd3
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_GAP    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_PFHOLD = 3'd5
    } mem_state_e;

    localparam int unsigned RETRY_GAP_DEF = 32'd2;
    localparam int unsigned TIMEOUT_DEF   = 32'd255;
    localparam int unsigned MAX_RETRY_DEF = 32'd7;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 32'd1) ? 32'd1 : $clog2(max_val + 32'd1);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: saturating up-counter with synchronous clear and enable.
//   clk, resetN - clock and asynchronous active-low reset
//   clr_i       - return count to zero (wins over en_i)
//   en_i        - count one step; holds at MAX_COUNT, never wraps
//   tc_o        - count has reached MAX_COUNT
module mem_timeout_ctr
    import ebox_mem_pkg::*;
#(
    parameter int unsigned MAX_COUNT = TIMEOUT_DEF,
    localparam int unsigned W        = cnt_width(MAX_COUNT)
)(
    input  logic clk,
    input  logic resetN,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q;

    assign tc_o = (cnt_q == W'(MAX_COUNT));

    // count register: clear, saturating increment, or hold
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= {W{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {W{1'b0}};
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/ebox_mem_seq.sv
// ebox_mem_seq: runs one EBOX memory cycle at a time against the cache port.
//   clk, resetN                 - clock, asynchronous active-low reset
//   memReq, memOp, user, public - microcode request and its attributes
//   cshEBOXT0, cshEBOXRetry     - cache accept / reject of the request
//   mboxDataValid               - read data or write ack returned
//   pfEBOXHandle, pfClear       - page fail on this cycle / dispatch done
//   eboxReq, eboxOp, ptUser, ptPublic - request and latched attributes
//   mboxXfer, force1777, nxmErr - one-cycle status pulses
//   memBusy, pfHold             - cycle in progress / held in page fail
module ebox_mem_seq
    import ebox_mem_pkg::*;
#(
    parameter int unsigned RETRY_GAP = RETRY_GAP_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
)(
    input  logic       clk,
    input  logic       resetN,
    input  logic       memReq,
    input  logic [1:0] memOp,
    input  logic       user,
    input  logic       public,
    input  logic       cshEBOXT0,
    input  logic       cshEBOXRetry,
    input  logic       mboxDataValid,
    input  logic       pfEBOXHandle,
    input  logic       pfClear,
    output logic       eboxReq,
    output logic [1:0] eboxOp,
    output logic       ptUser,
    output logic       ptPublic,
    output logic       mboxXfer,
    output logic       memBusy,
    output logic       pfHold,
    output logic       force1777,
    output logic       nxmErr
);

    localparam int unsigned RW = cnt_width(MAX_RETRY);

    mem_state_e    state_q;
    logic [RW-1:0] retry_q;
    logic          eboxReq_q, ptUser_q, ptPublic_q, mboxXfer_q;
    logic          pfHold_q, force1777_q, nxmErr_q;
    logic [1:0]    eboxOp_q;

    logic to_clr_s, to_en_s, to_tc_s;
    logic gap_clr_s, gap_en_s, gap_tc_s;

    // Timeout runs across REQ, GAP and WAIT; idle, pause and page-fail clear it.
    assign to_en_s   = (state_q == ST_REQ) || (state_q == ST_GAP) || (state_q == ST_WAIT);
    assign to_clr_s  = !to_en_s;
    // Gap counter restarts every time GAP is entered.
    assign gap_en_s  = (state_q == ST_GAP);
    assign gap_clr_s = !gap_en_s;

    mem_timeout_ctr #(.MAX_COUNT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .resetN (resetN),
        .clr_i  (to_clr_s),
        .en_i   (to_en_s),
        .tc_o   (to_tc_s)
    );

    mem_timeout_ctr #(.MAX_COUNT(RETRY_GAP - 32'd1)) u_gap (
        .clk    (clk),
        .resetN (resetN),
        .clr_i  (gap_clr_s),
        .en_i   (gap_en_s),
        .tc_o   (gap_tc_s)
    );

    assign memBusy   = (state_q != ST_IDLE);
    assign eboxReq   = eboxReq_q;
    assign eboxOp    = eboxOp_q;
    assign ptUser    = ptUser_q;
    assign ptPublic  = ptPublic_q;
    assign mboxXfer  = mboxXfer_q;
    assign pfHold    = pfHold_q;
    assign force1777 = force1777_q;
    assign nxmErr    = nxmErr_q;

    // Sequencer FSM; eboxReq and pfHold are registered as "next state is REQ/PFHOLD".
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            retry_q     <= {RW{1'b0}};
            eboxReq_q   <= 1'b0;
            eboxOp_q    <= 2'd0;
            ptUser_q    <= 1'b0;
            ptPublic_q  <= 1'b0;
            mboxXfer_q  <= 1'b0;
            pfHold_q    <= 1'b0;
            force1777_q <= 1'b0;
            nxmErr_q    <= 1'b0;
        end else begin
            eboxReq_q   <= 1'b0;
            mboxXfer_q  <= 1'b0;
            pfHold_q    <= 1'b0;
            force1777_q <= 1'b0;
            nxmErr_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // write-after-RPW is only meaningful from PAUSE
                    if (memReq && (memOp != MEM_WAR)) begin
                        eboxOp_q   <= memOp;
                        ptUser_q   <= user;
                        ptPublic_q <= public;
                        retry_q    <= {RW{1'b0}};
                        eboxReq_q  <= 1'b1;
                        state_q    <= ST_REQ;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (pfEBOXHandle) begin
                        pfHold_q    <= 1'b1;
                        force1777_q <= 1'b1;
                        state_q     <= ST_PFHOLD;
                    end else if (cshEBOXRetry) begin
                        if (retry_q == RW'(MAX_RETRY)) begin
                            nxmErr_q <= 1'b1;
                            state_q  <= ST_IDLE;
                        end else begin
                            retry_q  <= retry_q + RW'(1);
                            state_q  <= ST_GAP;
                        end
                    end else if (to_tc_s) begin
                        nxmErr_q  <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (cshEBOXT0) begin
                        state_q   <= ST_WAIT;
                    end else begin
                        eboxReq_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_GAP: begin
                    if (pfEBOXHandle) begin
                        pfHold_q    <= 1'b1;
                        force1777_q <= 1'b1;
                        state_q     <= ST_PFHOLD;
                    end else if (gap_tc_s) begin
                        eboxReq_q   <= 1'b1;
                        state_q     <= ST_REQ;
                    end else begin
                        state_q     <= ST_GAP;
                    end
                end
                ST_WAIT: begin
                    if (pfEBOXHandle) begin
                        pfHold_q    <= 1'b1;
                        force1777_q <= 1'b1;
                        state_q     <= ST_PFHOLD;
                    end else if (to_tc_s) begin
                        nxmErr_q    <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (mboxDataValid) begin
                        mboxXfer_q  <= 1'b1;
                        state_q     <= (eboxOp_q == MEM_RPW) ? ST_PAUSE : ST_IDLE;
                    end else begin
                        state_q     <= ST_WAIT;
                    end
                end
                ST_PAUSE: begin
                    if (pfEBOXHandle) begin
                        pfHold_q    <= 1'b1;
                        force1777_q <= 1'b1;
                        state_q     <= ST_PFHOLD;
                    end else if (memReq && (memOp == MEM_WAR)) begin
                        eboxOp_q    <= memOp;
                        ptUser_q    <= user;
                        ptPublic_q  <= public;
                        retry_q     <= {RW{1'b0}};
                        eboxReq_q   <= 1'b1;
                        state_q     <= ST_REQ;
                    end else begin
                        state_q     <= ST_PAUSE;
                    end
                end
                ST_PFHOLD: begin
                    if (pfClear) begin
                        state_q  <= ST_IDLE;
                    end else begin
                        pfHold_q <= 1'b1;
                        state_q  <= ST_PFHOLD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ebox_mem_seq.sv
// tb_ebox_mem_seq: directed self-checking bench for ebox_mem_seq.
// dut_a uses default parameters; dut_b shares its inputs and uses TIMEOUT=10.
module tb_ebox_mem_seq;

    logic       clk = 1'b0;
    logic       resetN;
    logic       memReq, user, public, t0, retry, dv, pf, pfClear;
    logic [1:0] memOp;

    logic       er_a, x_a, busy_a, ph_a, f_a, n_a, pu_a, pp_a;
    logic [1:0] op_a;
    logic       er_b, x_b, busy_b, ph_b, f_b, n_b, pu_b, pp_b;
    logic [1:0] op_b;
    logic [9:0] out_a, out_b;

    int n_cmp = 0;
    int n_bad = 0;

    assign out_a = {er_a, op_a, pu_a, pp_a, x_a, busy_a, ph_a, f_a, n_a};
    assign out_b = {er_b, op_b, pu_b, pp_b, x_b, busy_b, ph_b, f_b, n_b};

    always #5 clk = ~clk;

    ebox_mem_seq dut_a (
        .clk(clk), .resetN(resetN), .memReq(memReq), .memOp(memOp), .user(user),
        .public(public), .cshEBOXT0(t0), .cshEBOXRetry(retry), .mboxDataValid(dv),
        .pfEBOXHandle(pf), .pfClear(pfClear), .eboxReq(er_a), .eboxOp(op_a),
        .ptUser(pu_a), .ptPublic(pp_a), .mboxXfer(x_a), .memBusy(busy_a),
        .pfHold(ph_a), .force1777(f_a), .nxmErr(n_a)
    );

    ebox_mem_seq #(.TIMEOUT(10)) dut_b (
        .clk(clk), .resetN(resetN), .memReq(memReq), .memOp(memOp), .user(user),
        .public(public), .cshEBOXT0(t0), .cshEBOXRetry(retry), .mboxDataValid(dv),
        .pfEBOXHandle(pf), .pfClear(pfClear), .eboxReq(er_b), .eboxOp(op_b),
        .ptUser(pu_b), .ptPublic(pp_b), .mboxXfer(x_b), .memBusy(busy_b),
        .pfHold(ph_b), .force1777(f_b), .nxmErr(n_b)
    );

    // in  = {memReq, memOp, user, public, t0, retry, dv, pf, pfClear}
    // exp = {eboxReq, eboxOp, ptUser, ptPublic, mboxXfer, memBusy, pfHold, force1777, nxmErr}
    typedef struct packed {
        logic [9:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [0:22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        {memReq, memOp, user, public, t0, retry, dv, pf, pfClear} = 10'd0;
    endtask

    task automatic apply_reset();
        resetN = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        chk("reset_a", {22'd0, out_a}, 32'd0);
        chk("reset_b", {22'd0, out_b}, 32'd0);
        resetN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Request with no T0 (REQ timeout) or with T0 (WAIT timeout) on dut_b.
    task automatic timeout_run(input bit use_t0);
        apply_reset();
        for (int c = 0; c <= 13; c++) begin
            memReq = (c == 0);
            t0     = use_t0 && (c == 1);
            @(negedge clk);
            chk($sformatf("to%0d_nxm_c%0d", use_t0, c), {31'd0, n_b}, {31'd0, c == 12});
            chk($sformatf("to%0d_busy_c%0d", use_t0, c), {31'd0, busy_b},
                {31'd0, (c >= 1) && (c <= 11)});
            chk($sformatf("to%0d_req_c%0d", use_t0, c), {31'd0, er_b},
                {31'd0, use_t0 ? (c == 1) : ((c >= 1) && (c <= 11))});
            if (c == 12) chk("to_default_no_nxm", {31'd0, n_a}, 32'd0);
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{in: 10'b1_00_1_0_0_0_0_0_0, exp: 10'b0_00_0_0_0_0_0_0_0};
        tbl[1]  = '{in: 10'b0_00_0_0_0_0_0_0_0, exp: 10'b1_00_1_0_0_1_0_0_0};
        tbl[2]  = '{in: 10'b0_00_0_0_0_0_0_0_0, exp: 10'b1_00_1_0_0_1_0_0_0};
        tbl[3]  = '{in: 10'b0_00_0_0_1_0_0_0_0, exp: 10'b1_00_1_0_0_1_0_0_0};
        tbl[4]  = '{in: 10'b0_00_0_0_0_0_0_0_0, exp: 10'b0_00_1_0_0_1_0_0_0};
        tbl[5]  = '{in: 10'b0_00_0_0_0_0_0_0_0, exp: 10'b0_00_1_0_0_1_0_0_0};
        tbl[6]  = '{in: 10'b0_00_0_0_0_0_1_0_0, exp: 10'b0_00_1_0_0_1_0_0_0};
        tbl[7]  = '{in: 10'b0_00_0_0_0_0_0_0_0, exp: 10'b0_00_1_0_1_0_0_0_0};
        tbl[8]  = '{in: 10'b1_11_0_1_0_0_0_0_0, exp: 10'b0_00_1_0_0_0_0_0_0};
        tbl[9]  = '{in: 10'b0_00_0_0_0_0_0_0_0, exp: 10'b0_00_1_0_0_0_0_0_0};
        tbl[10] = '{in: 10'b1_01_0_1_0_0_0_0_0, exp: 10'b0_00_1_0_0_0_0_0_0};
        tbl[11] = '{in: 10'b0_00_0_0_1_0_0_0_0, exp: 10'b1_01_0_1_0_1_0_0_0};
        tbl[12] = '{in: 10'b0_00_0_0_0_0_1_0_0, exp: 10'b0_01_0_1_0_1_0_0_0};
        tbl[13] = '{in: 10'b1_10_1_1_0_0_0_0_0, exp: 10'b0_01_0_1_1_0_0_0_0};
        tbl[14] = '{in: 10'b0_00_0_0_1_0_0_0_0, exp: 10'b1_10_1_1_0_1_0_0_0};
        tbl[15] = '{in: 10'b0_00_0_0_0_0_1_0_0, exp: 10'b0_10_1_1_0_1_0_0_0};
        tbl[16] = '{in: 10'b1_00_0_0_0_0_0_0_0, exp: 10'b0_10_1_1_1_1_0_0_0};
        tbl[17] = '{in: 10'b1_00_0_0_0_0_0_0_0, exp: 10'b0_10_1_1_0_1_0_0_0};
        tbl[18] = '{in: 10'b1_11_0_0_0_0_0_0_0, exp: 10'b0_10_1_1_0_1_0_0_0};
        tbl[19] = '{in: 10'b0_00_0_0_1_0_0_0_0, exp: 10'b1_11_0_0_0_1_0_0_0};
        tbl[20] = '{in: 10'b0_00_0_0_0_0_1_0_0, exp: 10'b0_11_0_0_0_1_0_0_0};
        tbl[21] = '{in: 10'b0_00_0_0_0_0_0_0_0, exp: 10'b0_11_0_0_1_0_0_0_0};
        tbl[22] = '{in: 10'b0_00_0_0_0_0_0_0_0, exp: 10'b0_11_0_0_0_0_0_0_0};

        // Read, illegal op in IDLE, write, back-to-back RPW + write-after-RPW.
        apply_reset();
        for (int i = 0; i <= 22; i++) begin
            {memReq, memOp, user, public, t0, retry, dv, pf, pfClear} = tbl[i].in;
            @(negedge clk);
            chk($sformatf("tbl_a_c%0d", i), {22'd0, out_a}, {22'd0, tbl[i].exp});
            chk($sformatf("tbl_b_c%0d", i), {22'd0, out_b}, {22'd0, tbl[i].exp});
            next_cycle();
        end

        // Retry on every REQ cycle: 2-cycle gaps, 8th retry gives NXM.
        apply_reset();
        for (int c = 0; c <= 25; c++) begin
            memReq = (c == 0);
            retry  = (c >= 1) && (c <= 24);
            @(negedge clk);
            chk($sformatf("rty_req_c%0d", c), {31'd0, er_a},
                {31'd0, (c >= 1) && (c <= 22) && (((c - 1) % 3) == 0)});
            chk($sformatf("rty_nxm_c%0d", c), {31'd0, n_a}, {31'd0, c == 23});
            chk($sformatf("rty_busy_c%0d", c), {31'd0, busy_a}, {31'd0, (c >= 1) && (c <= 22)});
            next_cycle();
        end

        // Page fail in WAIT, cleared 5 cycles later; early pfClear and late data ignored.
        apply_reset();
        for (int c = 0; c <= 10; c++) begin
            memReq  = (c == 0);
            t0      = (c == 1);
            pfClear = (c == 1) || (c == 8);
            pf      = (c == 3);
            dv      = (c == 4);
            @(negedge clk);
            chk($sformatf("pf_f1777_c%0d", c), {31'd0, f_a}, {31'd0, c == 4});
            chk($sformatf("pf_hold_c%0d", c), {31'd0, ph_a}, {31'd0, (c >= 4) && (c <= 8)});
            chk($sformatf("pf_xfer_c%0d", c), {31'd0, x_a}, 32'd0);
            chk($sformatf("pf_busy_c%0d", c), {31'd0, busy_a}, {31'd0, (c >= 1) && (c <= 8)});
            next_cycle();
        end

        timeout_run(1'b0);
        timeout_run(1'b1);

        // Asynchronous reset in the middle of WAIT, then a clean new cycle.
        apply_reset();
        memReq = 1'b1; memOp = 2'd2; user = 1'b1; public = 1'b1;
        next_cycle();
        memReq = 1'b0; t0 = 1'b1;
        next_cycle();
        t0 = 1'b0;
        @(negedge clk);
        chk("ar_in_wait", {22'd0, out_a}, {22'd0, 10'b0_10_1_1_0_1_0_0_0});
        #2;
        resetN = 1'b0;
        dv     = 1'b1;
        #1;
        chk("ar_immediate_a", {22'd0, out_a}, 32'd0);
        chk("ar_immediate_b", {22'd0, out_b}, 32'd0);
        next_cycle();
        chk("ar_held_a", {22'd0, out_a}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        dv     = 1'b0;
        next_cycle();
        memReq = 1'b1; memOp = 2'd1; user = 1'b0; public = 1'b1;
        @(negedge clk);
        chk("ar_restart_idle", {22'd0, out_a}, 32'd0);
        next_cycle();
        memReq = 1'b0;
        @(negedge clk);
        chk("ar_restart_req", {22'd0, out_a}, {22'd0, 10'b1_01_0_1_0_1_0_0_0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
